reg32_access_arbiter: RTL

REG32_ACCESS_ARBITER -- requirements
Module: reg32_access_arbiter

---
 rtl/reg32_access_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/reg32_access_arbiter.sv
// Two-requester arbiter guarding a single WIDTH-bit register.
// Requests use a 4-phase handshake; ties alternate via a priority pointer.
module reg32_access_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StHold
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               ptr_q, ptr_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               ack_q, ack_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [WIDTH-1:0]   reg_q, reg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Handshake signals of whichever requester currently owns the register.
  logic               req_own;
  logic               we_own;
  logic [WIDTH-1:0]   wdata_own;

  always_comb begin
    req_own   = owner_q ? req1 : req0;
    we_own    = owner_q ? we1 : we0;
    wdata_own = owner_q ? wdata1 : wdata0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (req0 || req1) begin
          // A lone requester wins outright; the pointer only breaks ties.
          owner_d = (req0 && req1) ? ptr_q : req1;
          gnt0_d  = ~owner_d;
          gnt1_d  = owner_d;
          state_d = StXfer;
        end
      end

      StXfer: begin
        rdata_d = reg_q;
        ack_d   = 1'b1;
        if (we_own) begin
          reg_d = wdata_own;
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = StHold;
      end

      StHold: begin
        if (!req_own) begin
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          ptr_d   = ~owner_q;
          state_d = StIdle;
        end
      end

      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      reg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    gnt0     = gnt0_q;
    gnt1     = gnt1_q;
    ack      = ack_q;
    rdata    = rdata_q;
    q        = reg_q;
    busy     = (state_q != StIdle);
    wr_count = cnt_q;
  end

endmodule
